// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers x/y/de from sync edges, checks
// line/frame lengths, declares lock and counts lit pixels per frame.
module vga_sync_monitor #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_TOTAL     = 525,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic [9:0]  x_rec,
    output logic [9:0]  y_rec,
    output logic        de,
    output logic        locked,
    output logic        frame_done,
    output logic [18:0] lit_count,
    output logic        err_hlen,
    output logic        err_vlen
);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [10:0] HV0 = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] HV1 = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] VV0 = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] VV1 = 11'(V_SYNC + V_BACK + V_ACTIVE);

    logic        hs_prev, vs_prev;
    logic [9:0]  h_cnt, v_cnt;
    logic [1:0]  state;
    logic [7:0]  good_cnt;
    logic [18:0] acc;

    logic        hs_edge, vs_edge, line_err, frame_err, win, de_n;
    logic [9:0]  h_next, v_inc, v_next;
    logic [1:0]  state_n;
    logic [7:0]  good_n;
    logic        eh_n, ev_n;

    always_comb begin
        hs_edge   = p_tick && (hsync == SYNC_POL) && (hs_prev != SYNC_POL);
        vs_edge   = p_tick && (vsync == SYNC_POL) && (vs_prev != SYNC_POL);
        line_err  = hs_edge && (({1'b0, h_cnt} + 11'd1) != 11'(H_TOTAL));
        h_next    = hs_edge ? '0 : ((h_cnt == '1) ? h_cnt : h_cnt + 10'd1);
        // Frame length includes an hsync edge landing on the same tick as vsync.
        v_inc     = (hs_edge && (v_cnt != '1)) ? v_cnt + 10'd1 : v_cnt;
        frame_err = vs_edge && ({1'b0, v_inc} != 11'(V_TOTAL));
        v_next    = vs_edge ? '0 : v_inc;
        win       = ({1'b0, h_next} >= HV0) && ({1'b0, h_next} < HV1) &&
                    ({1'b0, v_next} >= VV0) && ({1'b0, v_next} < VV1);
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        eh_n    = err_hlen;
        ev_n    = err_vlen;
        case (state)
            SEARCH: begin
                if (vs_edge) begin
                    good_n  = '0;
                    state_n = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (line_err || frame_err) begin
                    eh_n    = err_hlen | line_err;
                    ev_n    = err_vlen | frame_err;
                    state_n = SEARCH;
                end else if (vs_edge && state == MEASURE) begin
                    good_n = good_cnt + 8'd1;
                    if (good_n == 8'(LOCK_FRAMES))
                        state_n = LOCKED;
                end
            end
            default: state_n = SEARCH;
        endcase
        de_n = win && (state_n == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev    <= ~SYNC_POL;
            vs_prev    <= ~SYNC_POL;
            h_cnt      <= '0;
            v_cnt      <= '0;
            state      <= SEARCH;
            good_cnt   <= '0;
            acc        <= '0;
            x_rec      <= '0;
            y_rec      <= '0;
            de         <= 1'b0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            lit_count  <= '0;
            err_hlen   <= 1'b0;
            err_vlen   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (p_tick) begin
                hs_prev  <= hsync;
                vs_prev  <= vsync;
                h_cnt    <= h_next;
                v_cnt    <= v_next;
                state    <= state_n;
                good_cnt <= good_n;
                err_hlen <= eh_n;
                err_vlen <= ev_n;
                locked   <= (state_n == LOCKED);
                de       <= de_n;
                x_rec    <= de_n ? h_next - HV0[9:0] : '0;
                y_rec    <= de_n ? v_next - VV0[9:0] : '0;
                if (state != LOCKED || line_err || frame_err) begin
                    acc <= '0;
                end else if (vs_edge) begin
                    lit_count  <= acc;
                    acc        <= '0;
                    frame_done <= 1'b1;
                end else if (win && rgb != '0) begin
                    acc <= acc + 19'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a reduced 16x12 timing, run with
// both sync polarities in parallel from one generator.
module tb_vga_sync_monitor;

    localparam int HA = 8, HB = 2, HS = 2, HT = 16;
    localparam int VA = 6, VB = 2, VS = 1, VT = 12;

    logic        clk = 1'b0;
    logic        reset, p_tick, hsync, vsync, hs_n, vs_n;
    logic [11:0] rgb;

    logic [9:0]  x0, y0, x1, y1;
    logic        de0, lk0, fd0, eh0, ev0, de1, lk1, fd1, eh1, ev1;
    logic [18:0] lc0, lc1;

    int checks = 0, errors = 0;
    logic exp_eh = 1'b0, exp_ev = 1'b0;
    logic [18:0] q0[$], q1[$];

    always #5 clk = ~clk;
    assign hs_n = ~hsync;
    assign vs_n = ~vsync;

    vga_sync_monitor #(
        .H_ACTIVE(HA), .H_BACK(HB), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_BACK(VB), .V_SYNC(VS), .V_TOTAL(VT),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut0 (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .x_rec(x0), .y_rec(y0), .de(de0), .locked(lk0),
        .frame_done(fd0), .lit_count(lc0), .err_hlen(eh0), .err_vlen(ev0)
    );

    vga_sync_monitor #(
        .H_ACTIVE(HA), .H_BACK(HB), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_BACK(VB), .V_SYNC(VS), .V_TOTAL(VT),
        .SYNC_POL(1'b1), .LOCK_FRAMES(2)
    ) dut1 (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hs_n), .vsync(vs_n),
        .rgb(rgb), .x_rec(x1), .y_rec(y1), .de(de1), .locked(lk1),
        .frame_done(fd1), .lit_count(lc1), .err_hlen(eh1), .err_vlen(ev1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input logic e_lock);
        chk("locked0", 32'(lk0), 32'(e_lock));
        chk("err_hlen0", 32'(eh0), 32'(exp_eh));
        chk("err_vlen0", 32'(ev0), 32'(exp_ev));
        chk("locked1", 32'(lk1), 32'(e_lock));
        chk("err_hlen1", 32'(eh1), 32'(exp_eh));
        chk("err_vlen1", 32'(ev1), 32'(exp_ev));
    endtask

    task automatic check_zero();
        chk("zero_x0", 32'(x0), 0);   chk("zero_y0", 32'(y0), 0);
        chk("zero_de0", 32'(de0), 0); chk("zero_fd0", 32'(fd0), 0);
        chk("zero_lc0", 32'(lc0), 0);
        chk("zero_x1", 32'(x1), 0);   chk("zero_y1", 32'(y1), 0);
        chk("zero_de1", 32'(de1), 0); chk("zero_fd1", 32'(fd1), 0);
        chk("zero_lc1", 32'(lc1), 0);
        check_state(1'b0);
    endtask

    task automatic tick(input logic hs, input logic vs, input logic [11:0] c);
        @(negedge clk);
        hsync  = hs;
        vsync  = vs;
        rgb    = c;
        p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
    endtask

    // Pattern 1: 1-pixel border plus a 2x2 ball at (0,2); blanking carries
    // non-zero colour so de gating matters. Lit pixels: 24 + 2 = 26.
    function automatic logic [11:0] pix(input int hc, input int vc, input int pat);
        int x, y;
        x = hc - (HS + HB);
        y = vc - (VS + VB);
        if (pat == 0) return 12'h000;
        if (x < 0 || x >= HA || y < 0 || y >= VA) return 12'h00F;
        if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 12'hFFF;
        if (x < 2 && y >= 2 && y < 4) return 12'hFFF;
        return 12'h000;
    endfunction

    task automatic gen_frame(input int lines, input int short_line, input int pat,
                             input logic e_lock, input int reset_line);
        for (int vc = 0; vc < lines; vc++) begin
            int len;
            len = (vc == short_line) ? HT - 1 : HT;
            for (int hc = 0; hc < len; hc++) begin
                tick((hc < HS) ? 1'b0 : 1'b1, (vc < VS) ? 1'b0 : 1'b1, pix(hc, vc, pat));
                if (vc == 0 && hc == 0) check_state(e_lock);
                if (short_line >= 0 && vc == short_line + 1 && hc == 0) begin
                    exp_eh = 1'b1;
                    check_state(1'b0);
                end
                if (vc == reset_line && hc == 6) begin
                    @(negedge clk);
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    exp_eh = 1'b0;
                    exp_ev = 1'b0;
                    check_zero();
                end
            end
        end
    endtask

    task automatic push(input logic [18:0] v);
        q0.push_back(v);
        q1.push_back(v);
    endtask

    // Monitors: lit_count on every frame_done, and the coordinates at each de rise.
    logic fd0_q = 1'b0, fd1_q = 1'b0, de0_q = 1'b0, de1_q = 1'b0;
    int row0 = 0, row1 = 0;

    always @(negedge clk) begin
        if (fd0) begin
            chk("frame_done0_width", 32'(fd0_q), 0);
            chk("frame_done0_expected", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) chk("lit_count0", 32'(lc0), 32'(q0.pop_front()));
        end
        if (!lk0) row0 = 0;
        if (de0 && !de0_q) begin
            chk("x_first0", 32'(x0), 0);
            chk("y_row0", 32'(y0), 32'(row0));
            row0 = (row0 + 1) % VA;
        end
        fd0_q <= fd0;
        de0_q <= de0;
    end

    always @(negedge clk) begin
        if (fd1) begin
            chk("frame_done1_width", 32'(fd1_q), 0);
            chk("frame_done1_expected", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) chk("lit_count1", 32'(lc1), 32'(q1.pop_front()));
        end
        if (!lk1) row1 = 0;
        if (de1 && !de1_q) begin
            chk("x_first1", 32'(x1), 0);
            chk("y_row1", 32'(y1), 32'(row1));
            row1 = (row1 + 1) % VA;
        end
        fd1_q <= fd1;
        de1_q <= de1;
    end

    initial begin
        reset  = 1'b1;
        p_tick = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        rgb    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_zero();

        gen_frame(VT, -1, 0, 1'b0, -1);   // F1: enter MEASURE
        gen_frame(VT, -1, 0, 1'b0, -1);   // F2: one good frame
        gen_frame(VT, -1, 0, 1'b1, -1);   // F3: locked
        push(19'd0);
        gen_frame(VT, -1, 1, 1'b1, -1);   // F4: ball + border
        push(19'd26);
        gen_frame(VT, -1, 1, 1'b1, -1);   // F5
        push(19'd26);
        gen_frame(VT, 5, 0, 1'b1, -1);    // F6: 15-tick line drops lock
        gen_frame(VT, -1, 0, 1'b0, -1);   // F7
        gen_frame(VT, -1, 0, 1'b0, -1);   // F8
        gen_frame(VT, -1, 0, 1'b1, -1);   // F9: relocked, err_hlen sticky
        push(19'd0);
        gen_frame(VT - 1, -1, 0, 1'b1, -1); // F10: 11 lines
        exp_ev = 1'b1;
        gen_frame(VT, -1, 0, 1'b0, -1);   // F11: frame error, no frame_done
        gen_frame(VT, -1, 0, 1'b0, -1);   // F12
        gen_frame(VT, -1, 0, 1'b0, -1);   // F13
        gen_frame(VT, -1, 0, 1'b1, 4);    // F14: locked, then reset mid-frame
        gen_frame(VT, -1, 0, 1'b0, -1);   // F15
        gen_frame(VT, -1, 0, 1'b0, -1);   // F16
        gen_frame(VT, -1, 1, 1'b1, -1);   // F17: relocked after three edges
        push(19'd26);
        gen_frame(VT, -1, 0, 1'b1, -1);   // F18

        repeat (10) @(negedge clk);
        chk("queue0_drained", 32'(q0.size()), 0);
        chk("queue1_drained", 32'(q1.size()), 0);
        check_state(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
